// File: rtl/led_shift_driver.sv
// led_shift_driver: continuous refresh of an external SIPO LED chain (snapshot, shift MSB first, latch).
// Optional post-reset lamp test (all LEDs on for LAMP_FRAMES frames) is built with LED_LAMP_TEST_EN.
package led_shift_driver_pkg;
  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_LATCH = 2'b10
  } state_t;
endpackage

module led_shift_driver
  import led_shift_driver_pkg::*;
#(
  parameter int unsigned NLED        = 16,
  parameter int unsigned CLKDIV      = 4,
  parameter int unsigned LAMP_FRAMES = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NLED-1:0] led_in,
  output logic            sr_clk,
  output logic            sr_data,
  output logic            sr_latch,
  output logic            frame_done
);

  localparam int unsigned DW = $clog2(2 * CLKDIV);
  localparam int unsigned BW = (NLED > 1) ? $clog2(NLED) : 1;
  localparam logic [DW-1:0] DIV_HALF   = DW'(CLKDIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLKDIV - 1);
  localparam logic [DW-1:0] LATCH_LAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_FIRST  = BW'(NLED - 1);

  state_t          state, state_n;
  logic [NLED-1:0] shreg, shreg_n;
  logic [NLED-1:0] acc, acc_n;
  logic [BW-1:0]   bitcnt, bitcnt_n;
  logic [DW-1:0]   divcnt, divcnt_n;
  logic            sr_clk_n, sr_data_n, sr_latch_n, frame_done_n;
  logic            lamp_on;

`ifdef LED_LAMP_TEST_EN
  localparam int unsigned FW = $clog2(LAMP_FRAMES + 1);
  localparam logic [FW-1:0] FRAMES_SAT = FW'(LAMP_FRAMES);

  logic [FW-1:0] frame_cnt;

  // Completed-frame counter; saturates once the lamp test is over.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_done && (frame_cnt != FRAMES_SAT)) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign lamp_on = (frame_cnt != FRAMES_SAT);
`else
  // Lamp test compiled out; LAMP_FRAMES has no effect (always >= 1).
  assign lamp_on = (LAMP_FRAMES == 32'd0) && 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_LOAD;
      shreg  <= '0;
      acc    <= '0;
      bitcnt <= '0;
      divcnt <= '0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      acc    <= acc_n;
      bitcnt <= bitcnt_n;
      divcnt <= divcnt_n;
    end
  end

  // Registered outputs, computed from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr_clk     <= 1'b0;
      sr_data    <= 1'b0;
      sr_latch   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sr_clk     <= sr_clk_n;
      sr_data    <= sr_data_n;
      sr_latch   <= sr_latch_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state logic; events are OR-accumulated between snapshots.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    divcnt_n = divcnt;
    acc_n    = acc | led_in;

    case (state)
      ST_LOAD: begin
        shreg_n  = lamp_on ? '1 : (acc | led_in);
        bitcnt_n = BIT_FIRST;
        divcnt_n = '0;
        acc_n    = '0;
        state_n  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (divcnt == DIV_LAST) begin
          divcnt_n = '0;
          if (bitcnt == '0) begin
            state_n = ST_LATCH;
          end else begin
            shreg_n  = shreg << 1;
            bitcnt_n = bitcnt - 1'b1;
          end
        end else begin
          divcnt_n = divcnt + 1'b1;
        end
      end
      ST_LATCH: begin
        if (divcnt == LATCH_LAST) begin
          divcnt_n = '0;
          state_n  = ST_LOAD;
        end else begin
          divcnt_n = divcnt + 1'b1;
        end
      end
      default: begin
        state_n  = ST_LOAD;
        shreg_n  = '0;
        bitcnt_n = '0;
        divcnt_n = '0;
      end
    endcase

    sr_clk_n     = (state_n == ST_SHIFT) && (divcnt_n >= DIV_HALF);
    sr_data_n    = shreg_n[NLED-1];
    sr_latch_n   = (state_n == ST_LATCH);
    frame_done_n = (state_n == ST_LATCH) && (divcnt_n == LATCH_LAST);
  end

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: a 16-LED/CLKDIV=4 instance and a 4-LED/CLKDIV=1 instance.
`timescale 1ns/1ps
module tb_led_shift_driver;
  import led_shift_driver_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_a, reset_b;
  logic [15:0] led_a;
  logic [3:0]  led_b;
  logic        sr_clk_a, sr_data_a, sr_latch_a, frame_done_a;
  logic        sr_clk_b, sr_data_b, sr_latch_b, frame_done_b;

  int tests = 0;
  int fails = 0;

  // Results of the most recent captured frame on instance A.
  logic [15:0] cap_bits;
  int cap_rises, cap_first, cap_latch, cap_clk_in_latch, cap_len;
  // Results of the most recent captured frame on instance B.
  logic [3:0] capb_bits;
  int capb_rises, capb_first, capb_latch, capb_toggles, capb_len;

  led_shift_driver #(.NLED(16), .CLKDIV(4), .LAMP_FRAMES(8)) dut_a (
    .clock(clock), .reset(reset_a), .led_in(led_a),
    .sr_clk(sr_clk_a), .sr_data(sr_data_a), .sr_latch(sr_latch_a), .frame_done(frame_done_a)
  );

  led_shift_driver #(.NLED(4), .CLKDIV(1), .LAMP_FRAMES(1)) dut_b (
    .clock(clock), .reset(reset_b), .led_in(led_b),
    .sr_clk(sr_clk_b), .sr_data(sr_data_b), .sr_latch(sr_latch_b), .frame_done(frame_done_b)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  // Record one frame of A. no_wait=1: current negedge is already the LOAD cycle.
  // Optionally pulses pulse_mask onto led_a for one cycle at frame cycle pulse_cyc (1 = LOAD).
  task automatic capture_a(input bit no_wait, input int pulse_cyc, input logic [15:0] pulse_mask);
    int guard;
    int cyc;
    logic prev_clk;
    logic [15:0] saved;
    cap_bits = '0; cap_rises = 0; cap_first = 0; cap_latch = 0; cap_clk_in_latch = 0; cap_len = 0;
    saved = led_a;
    guard = 0;
    if (!no_wait) begin
      while ((frame_done_a !== 1'b1) && (guard < 400)) begin
        @(negedge clock);
        guard++;
      end
      if (guard >= 400) begin
        tests++; fails++;
        $display("FAIL capture_a_timeout: got no frame_done want frame_done within 400 cycles");
        return;
      end
      @(negedge clock);
    end
    prev_clk = 1'b0;
    cyc = 1;
    forever begin
      if (cyc == pulse_cyc) begin
        saved = led_a;
        led_a = led_a | pulse_mask;
      end
      if (cyc == pulse_cyc + 1) led_a = saved;
      if (sr_clk_a && !prev_clk) begin
        cap_rises++;
        cap_bits = {cap_bits[14:0], sr_data_a};
        if (cap_first == 0) cap_first = cyc;
      end
      if (sr_latch_a) begin
        cap_latch++;
        if (sr_clk_a) cap_clk_in_latch++;
      end
      prev_clk = sr_clk_a;
      if (frame_done_a) begin
        cap_len = cyc;
        break;
      end
      if (cyc >= 400) begin
        tests++; fails++;
        $display("FAIL capture_a_frame_timeout: got no frame end want end within 400 cycles");
        break;
      end
      cyc++;
      @(negedge clock);
    end
  endtask

  // Record the frame of B that follows the next frame_done.
  task automatic capture_b();
    int guard;
    int cyc;
    logic prev_clk;
    capb_bits = '0; capb_rises = 0; capb_first = 0; capb_latch = 0; capb_toggles = 0; capb_len = 0;
    guard = 0;
    while ((frame_done_b !== 1'b1) && (guard < 100)) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) begin
      tests++; fails++;
      $display("FAIL capture_b_timeout: got no frame_done want frame_done within 100 cycles");
      return;
    end
    @(negedge clock);
    prev_clk = sr_clk_b;
    cyc = 1;
    forever begin
      if (cyc > 1 && sr_clk_b !== prev_clk) capb_toggles++;
      if (sr_clk_b && !prev_clk) begin
        capb_rises++;
        capb_bits = {capb_bits[2:0], sr_data_b};
        if (capb_first == 0) capb_first = cyc;
      end
      if (sr_latch_b) capb_latch++;
      prev_clk = sr_clk_b;
      if (frame_done_b) begin
        capb_len = cyc;
        break;
      end
      if (cyc >= 100) begin
        tests++; fails++;
        $display("FAIL capture_b_frame_timeout: got no frame end want end within 100 cycles");
        break;
      end
      cyc++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1; led_a = '0; led_b = '0;
    repeat (3) @(negedge clock);
    tests++;
    if ({sr_clk_a, sr_data_a, sr_latch_a, frame_done_a} !== 4'b0000) begin
      fails++; $display("FAIL reset_outputs: got %b want 0000", {sr_clk_a, sr_data_a, sr_latch_a, frame_done_a});
    end
    tests++;
    if (dut_a.state !== ST_LOAD) begin
      fails++; $display("FAIL reset_state: got %0d want %0d", dut_a.state, ST_LOAD);
    end
    reset_b = 1'b0;
  endtask

  task automatic test_lamp();
    led_a = '0;
    reset_a = 1'b0;
    capture_a(1'b1, 0, '0);
    tests++;
    if (cap_first !== 6) begin fails++; $display("FAIL lamp_first_rise: got %0d want 6", cap_first); end
`ifdef LED_LAMP_TEST_EN
    tests++;
    if (cap_bits !== 16'hFFFF) begin fails++; $display("FAIL lamp_frame1: got %h want ffff", cap_bits); end
    for (int f = 2; f <= 4; f++) begin
      capture_a(1'b0, 0, '0);
      tests++;
      if (cap_bits !== 16'hFFFF) begin fails++; $display("FAIL lamp_frame%0d: got %h want ffff", f, cap_bits); end
    end
    repeat (30) @(negedge clock);
    reset_a = 1'b1;
    repeat (3) @(negedge clock);
    reset_a = 1'b0;
    capture_a(1'b1, 0, '0);
    tests++;
    if (cap_bits !== 16'hFFFF) begin fails++; $display("FAIL lamp_restart1: got %h want ffff", cap_bits); end
    for (int f = 2; f <= 8; f++) begin
      capture_a(1'b0, 0, '0);
      tests++;
      if (cap_bits !== 16'hFFFF) begin fails++; $display("FAIL lamp_restart%0d: got %h want ffff", f, cap_bits); end
    end
    capture_a(1'b0, 0, '0);
    tests++;
    if (cap_bits !== 16'h0000) begin fails++; $display("FAIL lamp_frame9: got %h want 0000", cap_bits); end
`else
    tests++;
    if (cap_bits !== 16'h0000) begin fails++; $display("FAIL no_lamp_frame1: got %h want 0000", cap_bits); end
    tests++;
    if (cap_len !== 133) begin fails++; $display("FAIL no_lamp_len: got %0d want 133", cap_len); end
`endif
  endtask

  task automatic test_static();
    led_a = 16'hA5C3;
    capture_a(1'b0, 0, '0);
    tests++;
    if (cap_bits !== 16'hA5C3) begin fails++; $display("FAIL static_bits: got %h want a5c3", cap_bits); end
    tests++;
    if (cap_rises !== 16) begin fails++; $display("FAIL static_rises: got %0d want 16", cap_rises); end
    tests++;
    if (cap_latch !== 4) begin fails++; $display("FAIL static_latch_len: got %0d want 4", cap_latch); end
    tests++;
    if (cap_clk_in_latch !== 0) begin fails++; $display("FAIL static_clk_in_latch: got %0d want 0", cap_clk_in_latch); end
    tests++;
    if (cap_first !== 6) begin fails++; $display("FAIL static_first_rise: got %0d want 6", cap_first); end
    capture_a(1'b0, 0, '0);
    tests++;
    if (cap_len !== 133) begin fails++; $display("FAIL static_frame_period: got %0d want 133", cap_len); end
    tests++;
    if (cap_bits !== 16'hA5C3) begin fails++; $display("FAIL static_bits_repeat: got %h want a5c3", cap_bits); end
  endtask

  task automatic test_pulse();
    led_a = '0;
    capture_a(1'b0, 0, '0);
    capture_a(1'b0, 30, 16'h0008);
    tests++;
    if (cap_bits !== 16'h0000) begin fails++; $display("FAIL pulse_same_frame: got %h want 0000", cap_bits); end
    capture_a(1'b0, 0, '0);
    tests++;
    if (cap_bits !== 16'h0008) begin fails++; $display("FAIL pulse_next_frame: got %h want 0008", cap_bits); end
    capture_a(1'b0, 0, '0);
    tests++;
    if (cap_bits !== 16'h0000) begin fails++; $display("FAIL pulse_cleared: got %h want 0000", cap_bits); end
    capture_a(1'b0, 1, 16'h0008);
    tests++;
    if (cap_bits !== 16'h0008) begin fails++; $display("FAIL pulse_on_load: got %h want 0008", cap_bits); end
    capture_a(1'b0, 0, '0);
    tests++;
    if (cap_bits !== 16'h0000) begin fails++; $display("FAIL pulse_on_load_cleared: got %h want 0000", cap_bits); end
  endtask

  task automatic test_illegal();
    led_a = 16'hA5C3;
    capture_a(1'b0, 0, '0);
    repeat (20) @(negedge clock);
    force dut_a.state = state_t'(2'b11);
    #1;
    release dut_a.state;
    @(negedge clock);
    tests++;
    if (dut_a.state !== ST_LOAD) begin fails++; $display("FAIL illegal_to_load: got %0d want %0d", dut_a.state, ST_LOAD); end
    tests++;
    if ({sr_clk_a, sr_data_a, sr_latch_a, frame_done_a} !== 4'b0000) begin
      fails++; $display("FAIL illegal_outputs: got %b want 0000", {sr_clk_a, sr_data_a, sr_latch_a, frame_done_a});
    end
    capture_a(1'b1, 0, '0);
    tests++;
    if (cap_bits !== 16'hA5C3) begin fails++; $display("FAIL illegal_next_frame: got %h want a5c3", cap_bits); end
    tests++;
    if (cap_len !== 133) begin fails++; $display("FAIL illegal_next_len: got %0d want 133", cap_len); end
  endtask

  task automatic test_min_div();
    led_b = 4'b1001;
    capture_b();
    capture_b();
    tests++;
    if (capb_len !== 10) begin fails++; $display("FAIL mindiv_len: got %0d want 10", capb_len); end
    tests++;
    if (capb_bits !== 4'b1001 || capb_rises !== 4) begin
      fails++; $display("FAIL mindiv_bits: got %b/%0d rises want 1001/4 rises", capb_bits, capb_rises);
    end
    tests++;
    if (capb_latch !== 1) begin fails++; $display("FAIL mindiv_latch_len: got %0d want 1", capb_latch); end
    tests++;
    if (capb_toggles !== 8 || capb_first !== 3) begin
      fails++; $display("FAIL mindiv_toggle: got %0d toggles first %0d want 8 toggles first 3", capb_toggles, capb_first);
    end
  endtask

  task automatic test_reset_midframe();
    int latch_seen;
    led_a = 16'hA5C3;
    capture_a(1'b0, 0, '0);
    repeat (6) @(negedge clock);
    tests++;
    if ({sr_clk_a, sr_data_a} !== 2'b11) begin fails++; $display("FAIL midframe_pre: got %b want 11", {sr_clk_a, sr_data_a}); end
    reset_a = 1'b1;
    @(negedge clock);
    tests++;
    if ({sr_clk_a, sr_data_a, sr_latch_a, frame_done_a} !== 4'b0000) begin
      fails++; $display("FAIL midframe_reset_outputs: got %b want 0000", {sr_clk_a, sr_data_a, sr_latch_a, frame_done_a});
    end
    latch_seen = 0;
    repeat (2) begin
      @(negedge clock);
      if (sr_latch_a) latch_seen++;
    end
    tests++;
    if (latch_seen !== 0) begin fails++; $display("FAIL midframe_no_latch: got %0d latch cycles want 0", latch_seen); end
    reset_a = 1'b0;
    tests++;
    if (dut_a.state !== ST_LOAD) begin fails++; $display("FAIL midframe_starts_load: got %0d want %0d", dut_a.state, ST_LOAD); end
    capture_a(1'b1, 0, '0);
    tests++;
    if (cap_first !== 6 || cap_len !== 133 || cap_latch !== 4) begin
      fails++; $display("FAIL midframe_first_frame: got first %0d len %0d latch %0d want 6 133 4", cap_first, cap_len, cap_latch);
    end
`ifdef LED_LAMP_TEST_EN
    tests++;
    if (cap_bits !== 16'hFFFF) begin fails++; $display("FAIL midframe_bits: got %h want ffff", cap_bits); end
`else
    tests++;
    if (cap_bits !== 16'hA5C3) begin fails++; $display("FAIL midframe_bits: got %h want a5c3", cap_bits); end
`endif
  endtask

  initial begin
    test_reset();
    test_lamp();
    test_static();
    test_pulse();
    test_illegal();
    test_min_div();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
